vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA sync generator. Display timing, pixel-clock division and sync polarity are all set by parameters. Adds a pixel enable, a pipeline-alignment delay on the sync and blanking outputs, and line/frame start strobes. It sits between the system clock and the pixel generator / DAC output stage.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, h/v counters, sync/blank decode with
// a tick-aligned delay line, line/frame strobes. Optional frame counter via VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DELAY = 0,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_count,
`endif
  output logic          frame_start
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [3:0]    r_div_cnt;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_hs;
  logic          w_vs;
  logic          w_vid;

  assign w_tick   = en && (r_div_cnt == 4'd0);
  assign w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= 4'd0;
    end else if (en) begin
      r_div_cnt <= (r_div_cnt == 4'(CLK_DIV - 1)) ? 4'd0 : r_div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  // Raw decode with polarity applied before the delay line.
  always_comb begin
    w_hs  = (r_h_cnt >= CW'(H_SYNC_START)) && (r_h_cnt < CW'(H_SYNC_END));
    w_vs  = (r_v_cnt >= CW'(V_SYNC_START)) && (r_v_cnt < CW'(V_SYNC_END));
    w_vid = (r_h_cnt < CW'(H_DISPLAY)) && (r_v_cnt < CW'(V_DISPLAY));
    if (!HSYNC_POL) w_hs = !w_hs;
    if (!VSYNC_POL) w_vs = !w_vs;
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign hsync    = w_hs;
      assign vsync    = w_vs;
      assign video_on = w_vid;
    end else begin : g_pipe
      localparam logic [2:0] IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};
      logic [2:0] r_pipe [PIPE_DELAY];

      // NOTE: every delay stage is reset, so a reset never lets a stale partial sync pulse escape.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= IDLE;
        end else if (w_tick) begin
          r_pipe[0] <= {w_hs, w_vs, w_vid};
          for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign {hsync, vsync, video_on} = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= 16'd0;
    end else if (w_tick && w_h_last && w_v_last) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign p_tick      = w_tick;
  assign x           = r_h_cnt;
  assign y           = r_v_cnt;
  assign line_start  = w_tick && (r_h_cnt == '0);
  assign frame_start = w_tick && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances checked every clock against a tick-count
// model, plus directed period, pulse-width and wrap-corner measurements.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;  // 16
  localparam int VT = VD + VF + VS + VB;  // 11
  localparam int CW = 6;

  // Instance A: divided clock, two-tick delay line, active-high hsync.
  localparam int  DIV_A = 3, PD_A = 2;
  localparam bit  HP_A = 1'b1, VP_A = 1'b0;
  // Instance B: undivided clock, no delay line, active-high vsync.
  localparam int  DIV_B = 1, PD_B = 0;
  localparam bit  HP_B = 1'b0, VP_B = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  logic          p_tick_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic [CW-1:0] x_a, y_a;
  logic          p_tick_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [CW-1:0] x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_count_a, frame_count_b;
`endif

  int     n_checks = 0;
  int     n_fail = 0;
  longint e_a = 0;  // enabled clocks since reset, per instance
  longint e_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP_A), .VSYNC_POL(VP_A), .CLK_DIV(DIV_A), .PIPE_DELAY(PD_A), .CW(CW)
  ) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .p_tick(p_tick_a), .x(x_a), .y(y_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .line_start(line_start_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(frame_count_a),
`endif
    .frame_start(frame_start_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP_B), .VSYNC_POL(VP_B), .CLK_DIV(DIV_B), .PIPE_DELAY(PD_B), .CW(CW)
  ) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .p_tick(p_tick_b), .x(x_b), .y(y_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .line_start(line_start_b),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(frame_count_b),
`endif
    .frame_start(frame_start_b)
  );

  wire [17:0] obs_a = {p_tick_a, x_a, y_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a};
  wire [17:0] obs_b = {p_tick_b, x_b, y_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b};

  // Expected outputs from the number of enabled clocks since reset: ticks taken so far give the
  // raster position directly; delayed signals are the decode of the position N ticks earlier.
  function automatic logic [17:0] model(longint e, logic en_i, int d, int n, bit hp, bit vp);
    longint t, u;
    int     h, v, hd, vd;
    logic   pt, hs, vs, vid;
    t  = (e + d - 1) / d;
    h  = int'(t % HT);
    v  = int'((t / HT) % VT);
    pt = en_i && (e % d == 0);
    if (t >= n) begin
      u   = t - n;
      hd  = int'(u % HT);
      vd  = int'((u / HT) % VT);
      hs  = (hd >= HD + HF && hd < HD + HF + HS) ? hp : !hp;
      vs  = (vd >= VD + VF && vd < VD + VF + VS) ? vp : !vp;
      vid = (hd < HD) && (vd < VD);
    end else begin
      hs  = !hp;
      vs  = !vp;
      vid = 1'b0;
    end
    return {pt, 6'(h), 6'(v), hs, vs, vid, pt && h == 0, pt && h == 0 && v == 0};
  endfunction

  // Advance one clock and update both models with the inputs held across that edge.
  task automatic tick_model();
    @(posedge clk);
    if (reset) begin
      e_a = 0;
      e_b = 0;
    end else if (en) begin
      e_a++;
      e_b++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    e_a = 0;
    e_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = i[0];
      #1;
      n_checks++;
      if (obs_a !== model(e_a, en, DIV_A, PD_A, HP_A, VP_A)) begin
        n_fail++;
        $display("FAIL reset_a cyc=%0d got=%h exp=%h", i, obs_a, model(e_a, en, DIV_A, PD_A, HP_A, VP_A));
      end
      n_checks++;
      if (obs_b !== model(e_b, en, DIV_B, PD_B, HP_B, VP_B)) begin
        n_fail++;
        $display("FAIL reset_b cyc=%0d got=%h exp=%h", i, obs_b, model(e_b, en, DIV_B, PD_B, HP_B, VP_B));
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      n_checks++;
      if (frame_count_a !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_frame_count got=%0d exp=0", frame_count_a);
      end
`endif
      tick_model();
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 2 * HT * VT * DIV_A + 20; i++) begin
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      #1;
      n_checks++;
      if (obs_a !== model(e_a, en, DIV_A, PD_A, HP_A, VP_A)) begin
        n_fail++;
        $display("FAIL free_run_a cyc=%0d got=%h exp=%h", i, obs_a, model(e_a, en, DIV_A, PD_A, HP_A, VP_A));
      end
      n_checks++;
      if (obs_b !== model(e_b, en, DIV_B, PD_B, HP_B, VP_B)) begin
        n_fail++;
        $display("FAIL free_run_b cyc=%0d got=%h exp=%h", i, obs_b, model(e_b, en, DIV_B, PD_B, HP_B, VP_B));
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      n_checks++;
      if (frame_count_a !== 16'(((e_a + DIV_A - 1) / DIV_A) / (HT * VT))) begin
        n_fail++;
        $display("FAIL frame_count got=%0d exp=%0d", frame_count_a,
                 16'(((e_a + DIV_A - 1) / DIV_A) / (HT * VT)));
      end
`endif
      tick_model();
    end
  endtask

  task automatic test_enable_toggle();
    int low_run = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = 1'b0;
      if (low_run > 0) begin
        en = 1'b0;
        low_run--;
      end else begin
        en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) low_run = $urandom_range(3, 8);
      end
      #1;
      n_checks++;
      if (obs_a !== model(e_a, en, DIV_A, PD_A, HP_A, VP_A)) begin
        n_fail++;
        $display("FAIL en_toggle_a cyc=%0d en=%b got=%h exp=%h", i, en, obs_a,
                 model(e_a, en, DIV_A, PD_A, HP_A, VP_A));
      end
      n_checks++;
      if (obs_b !== model(e_b, en, DIV_B, PD_B, HP_B, VP_B)) begin
        n_fail++;
        $display("FAIL en_toggle_b cyc=%0d en=%b got=%h exp=%h", i, en, obs_b,
                 model(e_b, en, DIV_B, PD_B, HP_B, VP_B));
      end
      tick_model();
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    // Directed: land inside the sync pulses of instance A, then pulse reset.
    for (int i = 0; i < 2 * HT * VT * DIV_A && !found; i++) begin
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      #1;
      found = (x_a == 6'(HD + HF + 1)) && (y_a == 6'(VD + VF + 1));
      tick_model();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_frame_locate got=not_found exp=x%0d_y%0d", HD + HF + 1, VD + VF + 1);
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(0, 150) == 0);
      en    = ($urandom_range(0, 4) != 0);
      #1;
      n_checks++;
      if (obs_a !== model(e_a, en, DIV_A, PD_A, HP_A, VP_A)) begin
        n_fail++;
        $display("FAIL reset_mid_a cyc=%0d rst=%b got=%h exp=%h", i, reset, obs_a,
                 model(e_a, en, DIV_A, PD_A, HP_A, VP_A));
      end
      n_checks++;
      if (obs_b !== model(e_b, en, DIV_B, PD_B, HP_B, VP_B)) begin
        n_fail++;
        $display("FAIL reset_mid_b cyc=%0d rst=%b got=%h exp=%h", i, reset, obs_b,
                 model(e_b, en, DIV_B, PD_B, HP_B, VP_B));
      end
      tick_model();
    end
  endtask

  task automatic test_line_period();
    bit seen;
    int n, cnt;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    // Instance B: line period and active-low hsync width in clocks.
    seen = 1'b0;
    for (int i = 0; i < 4 * HT && !seen; i++) begin
      tick_model();
      @(negedge clk);
      #1;
      seen = line_start_b;
    end
    n = 0;
    cnt = 0;
    while (seen && n < 4 * HT) begin
      tick_model();
      @(negedge clk);
      #1;
      n++;
      cnt += int'(!hsync_b);
      if (line_start_b) break;
    end
    n_checks++;
    if (n !== HT * DIV_B) begin
      n_fail++;
      $display("FAIL line_period_b got=%0d exp=%0d", n, HT * DIV_B);
    end
    n_checks++;
    if (cnt !== HS * DIV_B) begin
      n_fail++;
      $display("FAIL hsync_width_b got=%0d exp=%0d", cnt, HS * DIV_B);
    end
    // Instance A: line period and active-high hsync width after the delay line.
    seen = 1'b0;
    for (int i = 0; i < 4 * HT * DIV_A && !seen; i++) begin
      tick_model();
      @(negedge clk);
      #1;
      seen = line_start_a;
    end
    n = 0;
    cnt = 0;
    while (seen && n < 4 * HT * DIV_A) begin
      tick_model();
      @(negedge clk);
      #1;
      n++;
      cnt += int'(hsync_a);
      if (line_start_a) break;
    end
    n_checks++;
    if (n !== HT * DIV_A) begin
      n_fail++;
      $display("FAIL line_period_a got=%0d exp=%0d", n, HT * DIV_A);
    end
    n_checks++;
    if (cnt !== HS * DIV_A) begin
      n_fail++;
      $display("FAIL hsync_width_a got=%0d exp=%0d", cnt, HS * DIV_A);
    end
    // Instance B: visible clocks per frame.
    cnt = 0;
    for (int i = 0; i < HT * VT * DIV_B; i++) begin
      tick_model();
      @(negedge clk);
      #1;
      cnt += int'(video_on_b);
    end
    n_checks++;
    if (cnt !== HD * VD * DIV_B) begin
      n_fail++;
      $display("FAIL video_on_count_b got=%0d exp=%0d", cnt, HD * VD * DIV_B);
    end
  endtask

  task automatic test_corner_wrap();
    bit found = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      tick_model();
      @(negedge clk);
      #1;
      found = (x_b == 6'(HT - 1)) && (y_b == 6'(VT - 1));
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL corner_locate got=not_found exp=x%0d_y%0d", HT - 1, VT - 1);
    end
    tick_model();
    @(negedge clk);
    #1;
    n_checks++;
    if ({x_b, y_b, frame_start_b, line_start_b} !== {6'd0, 6'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL corner_wrap got=x%0d_y%0d_fs%b_ls%b exp=x0_y0_fs1_ls1", x_b, y_b, frame_start_b,
               line_start_b);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_enable_toggle();
    test_reset_mid_frame();
    test_line_period();
    test_corner_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
